video_pattern_gen: RTL and testbench

VIDEO_PATTERN_GEN -- requirements
Module: video_pattern_gen

---
 rtl/video_pattern_gen.sv | 152 +++++++++++++++
 tb/tb_video_pattern_gen.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/video_pattern_gen.sv
// Video timing and test-pattern generator (colour bars, grid, gradient, solid).
// Optional feature: define VPG_FRAME_CNT_EN to add a 16-bit frame counter
// output and make the gradient pattern scroll horizontally by frame_cnt[7:0].
module video_pattern_gen #(
  parameter logic [11:0] H_DISP  = 12'd1280,
  parameter logic [11:0] V_DISP  = 12'd720,
  parameter logic [11:0] H_FRONT = 12'd110,
  parameter logic [11:0] H_SYNC  = 12'd40,
  parameter logic [11:0] H_BACK  = 12'd220,
  parameter logic [11:0] V_FRONT = 12'd5,
  parameter logic [11:0] V_SYNC  = 12'd5,
  parameter logic [11:0] V_BACK  = 12'd20
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic [1:0]  mode,
  input  logic [15:0] solid_color,
  output logic        post_vs,
  output logic        post_de,
  output logic [15:0] post_data,
  output logic        busy,
`ifdef VPG_FRAME_CNT_EN
  output logic [15:0] frame_cnt,
`endif
  output logic        frame_done
);

  localparam logic [11:0] H_TOTAL   = H_DISP + H_FRONT + H_SYNC + H_BACK;
  localparam logic [11:0] V_TOTAL   = V_DISP + V_FRONT + V_SYNC + V_BACK;
  localparam logic [11:0] VS_START  = V_DISP + V_FRONT;
  localparam logic [11:0] VS_END    = V_DISP + V_FRONT + V_SYNC;

  typedef enum logic {IDLE, RUN} state_t;

  state_t      state, state_next;
  logic [11:0] h_cnt, v_cnt;
  logic        h_last, v_last, frame_last, frame_start;
  logic [1:0]  mode_q, mode_eff;
  logic [15:0] color_q, color_eff;
  logic [2:0]  bar_idx;
  logic [5:0]  grad_hi;
  logic        de, vsync;
  logic [15:0] pixel;

  assign h_last      = (h_cnt == H_TOTAL - 12'd1);
  assign v_last      = (v_cnt == V_TOTAL - 12'd1);
  assign frame_last  = (state == RUN) && h_last && v_last;
  assign frame_start = (state == RUN) && (h_cnt == '0) && (v_cnt == '0);
  assign busy        = (state == RUN);

  // The first pixel of a frame must already use the freshly sampled settings,
  // so the live inputs bypass the latch on that one cycle.
  assign mode_eff  = frame_start ? mode : mode_q;
  assign color_eff = frame_start ? solid_color : color_q;

  assign de      = (h_cnt < H_DISP) && (v_cnt < V_DISP);
  assign vsync   = (v_cnt >= VS_START) && (v_cnt < VS_END);
  assign bar_idx = 3'({h_cnt, 3'b000} / 15'(H_DISP));

`ifdef VPG_FRAME_CNT_EN
  assign grad_hi = 6'((h_cnt[7:0] + frame_cnt[7:0]) >> 2);
`else
  assign grad_hi = h_cnt[7:2];
`endif

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state logic: leave RUN only at the end of a complete frame
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (enable) state_next = RUN;
      RUN:     if (frame_last && !enable) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Raster counters, held at the origin outside RUN
  always_ff @(posedge clk) begin
    if (rst || state == IDLE) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (h_last) begin
      h_cnt <= '0;
      v_cnt <= v_last ? '0 : v_cnt + 12'd1;
    end else begin
      h_cnt <= h_cnt + 12'd1;
    end
  end

  // Pattern settings captured once per frame
  always_ff @(posedge clk) begin
    if (rst) begin
      mode_q  <= '0;
      color_q <= '0;
    end else if (frame_start) begin
      mode_q  <= mode;
      color_q <= solid_color;
    end
  end

  // Pixel colour for the current counter position
  always_comb begin
    pixel = '0;
    case (mode_eff)
      2'b00: begin
        case (bar_idx)
          3'd0: pixel = 16'hFFFF;
          3'd1: pixel = 16'hFFE0;
          3'd2: pixel = 16'h07FF;
          3'd3: pixel = 16'h07E0;
          3'd4: pixel = 16'hF81F;
          3'd5: pixel = 16'hF800;
          3'd6: pixel = 16'h001F;
          default: pixel = 16'h0000;
        endcase
      end
      2'b01:   pixel = (h_cnt[4:0] == '0 || v_cnt[4:0] == '0) ? 16'hFFFF : 16'h0000;
      2'b10:   pixel = {grad_hi[5:1], grad_hi, v_cnt[7:3]};
      default: pixel = color_eff;
    endcase
  end

  // Registered video outputs, one cycle behind the counters
  always_ff @(posedge clk) begin
    if (rst || state == IDLE) begin
      post_vs    <= 1'b0;
      post_de    <= 1'b0;
      post_data  <= '0;
      frame_done <= 1'b0;
    end else begin
      post_vs    <= vsync;
      post_de    <= de;
      post_data  <= de ? pixel : 16'h0000;
      frame_done <= frame_last;
    end
  end

`ifdef VPG_FRAME_CNT_EN
  // Completed-frame counter, stepped together with frame_done
  always_ff @(posedge clk) begin
    if (rst)             frame_cnt <= '0;
    else if (frame_last) frame_cnt <= frame_cnt + 16'd1;
  end
`endif

endmodule

// File: tb/tb_video_pattern_gen.sv
// Self-checking bench for video_pattern_gen using a small raster-position
// reference model (frame position index -> x/y) with directed and random steps.
module tb_video_pattern_gen;

  localparam int HD = 16, VD = 4, HF = 2, HS = 2, HB = 2, VF = 1, VS = 1, VB = 1;
  localparam int HT = HD + HF + HS + HB;
  localparam int VT = VD + VF + VS + VB;
  localparam int FT = HT * VT;
`ifdef VPG_FRAME_CNT_EN
  localparam bit FC_EN = 1'b1;
`else
  localparam bit FC_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst, enable;
  logic [1:0]  mode;
  logic [15:0] solid_color;
  logic        post_vs, post_de, busy, frame_done;
  logic [15:0] post_data;
`ifdef VPG_FRAME_CNT_EN
  logic [15:0] frame_cnt;
`endif

  always #5 clk = ~clk;

  video_pattern_gen #(
    .H_DISP(12'(HD)), .V_DISP(12'(VD)),
    .H_FRONT(12'(HF)), .H_SYNC(12'(HS)), .H_BACK(12'(HB)),
    .V_FRONT(12'(VF)), .V_SYNC(12'(VS)), .V_BACK(12'(VB))
  ) dut (
    .clk(clk), .rst(rst), .enable(enable), .mode(mode),
    .solid_color(solid_color),
    .post_vs(post_vs), .post_de(post_de), .post_data(post_data),
    .busy(busy),
`ifdef VPG_FRAME_CNT_EN
    .frame_cnt(frame_cnt),
`endif
    .frame_done(frame_done)
  );

  int vectors = 0, miscompares = 0;
  int de_count = 0, vs_count = 0, fd_count = 0;

  // reference model state
  bit          m_run = 1'b0;
  int          m_pos = 0;
  logic [1:0]  m_mode = '0;
  logic [15:0] m_color = '0;
  int          m_fc = 0;
  logic        e_vs, e_de, e_busy, e_fd;
  logic [15:0] e_data;

  function automatic logic [15:0] ref_pixel(int x, int y, logic [1:0] md,
                                            logic [15:0] col, int fc);
    logic [15:0] bars [8] = '{16'hFFFF, 16'hFFE0, 16'h07FF, 16'h07E0,
                              16'hF81F, 16'hF800, 16'h001F, 16'h0000};
    int s;
    case (md)
      2'd0: return bars[(x * 8) / HD];
      2'd1: return ((x % 32 == 0) || (y % 32 == 0)) ? 16'hFFFF : 16'h0000;
      2'd2: begin
        s = (x + fc) % 256;
        return 16'((((s / 8) % 32) * 2048) + (((s / 4) % 64) * 32) + ((y / 8) % 32));
      end
      default: return col;
    endcase
  endfunction

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic cyc(input logic r, input logic en, input logic [1:0] md,
                     input logic [15:0] col);
    int x, y;
    rst = r; enable = en; mode = md; solid_color = col;
    @(posedge clk);
    e_vs = 0; e_de = 0; e_data = '0; e_fd = 0;
    if (r) begin
      m_run = 0; m_pos = 0; m_mode = '0; m_color = '0; m_fc = 0;
    end else if (!m_run) begin
      if (en) m_run = 1;
      m_pos = 0;
    end else begin
      x = m_pos % HT;
      y = m_pos / HT;
      if (m_pos == 0) begin m_mode = md; m_color = col; end
      e_de   = (x < HD) && (y < VD);
      e_vs   = (y >= VD + VF) && (y < VD + VF + VS);
      e_data = e_de ? ref_pixel(x, y, m_mode, m_color, FC_EN ? m_fc : 0) : 16'h0000;
      e_fd   = (m_pos == FT - 1);
      if (e_fd) begin
        m_fc  = (m_fc + 1) % 65536;
        m_pos = 0;
        if (!en) m_run = 0;
      end else begin
        m_pos++;
      end
    end
    e_busy = m_run;
    @(negedge clk);
    check("post_vs", 16'(post_vs), 16'(e_vs));
    check("post_de", 16'(post_de), 16'(e_de));
    check("post_data", post_data, e_data);
    check("busy", 16'(busy), 16'(e_busy));
    check("frame_done", 16'(frame_done), 16'(e_fd));
`ifdef VPG_FRAME_CNT_EN
    check("frame_cnt", frame_cnt, 16'(m_fc));
`endif
    de_count += int'(post_de);
    vs_count += int'(post_vs);
    fd_count += int'(frame_done);
  endtask

  task automatic clear_stats();
    de_count = 0; vs_count = 0; fd_count = 0;
  endtask

  initial begin
    logic        r_en;
    logic [1:0]  r_md;
    logic [15:0] r_col;

    // reset state
    repeat (3) cyc(1'b1, 1'b0, 2'b00, 16'h0000);
    // no start while reset held, nor while enable low
    repeat (3) cyc(1'b1, 1'b1, 2'b00, 16'h0000);
    repeat (5) cyc(1'b0, 1'b0, 2'b00, 16'h0000);

    // colour bars: start edge plus one complete frame
    clear_stats();
    repeat (1 + FT) cyc(1'b0, 1'b1, 2'b00, 16'h0000);
    check("bars_de_cycles", 16'(de_count), 16'(HD * VD));
    check("bars_vs_cycles", 16'(vs_count), 16'(HT * VS));
    check("bars_fd_pulses", 16'(fd_count), 16'd1);

    // solid colour changed mid-frame applies from the next frame
    repeat (60) cyc(1'b0, 1'b1, 2'b11, 16'h1234);
    repeat (FT - 60 + FT) cyc(1'b0, 1'b1, 2'b11, 16'h07E0);

    // enable dropped on line 1: frame finishes, then idle
    clear_stats();
    repeat (HT) cyc(1'b0, 1'b1, 2'b00, 16'h0000);
    repeat (FT - HT + 10) cyc(1'b0, 1'b0, 2'b00, 16'h0000);
    check("stop_fd_pulses", 16'(fd_count), 16'd1);
    check("stop_idle_busy", 16'(busy), 16'd0);

    // grid frame
    repeat (1 + FT) cyc(1'b0, 1'b1, 2'b01, 16'h0000);

    // reset in the middle of line 2, then restart from the origin
    repeat (2 * HT + 7) cyc(1'b0, 1'b1, 2'b01, 16'h0000);
    cyc(1'b1, 1'b1, 2'b01, 16'h0000);
    repeat (1 + FT) cyc(1'b0, 1'b1, 2'b00, 16'h0000);

    // gradient frames (scroll with frame counter when present)
    repeat (3 * FT) cyc(1'b0, 1'b1, 2'b10, 16'h0000);

    // randomized run
    r_en = 1'b1; r_md = 2'b00; r_col = 16'hABCD;
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 199) == 0) r_en = ~r_en;
      if ($urandom_range(0, 29) == 0) r_md = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 9) == 0) r_col = 16'($urandom);
      cyc(($urandom_range(0, 999) == 0), r_en, r_md, r_col);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
